// File: rtl/ControlSignals.sv
// Shared control definitions for the instruction-memory responder:
// FSM state encoding and the NOP word returned on idle/error responses.
package ControlSignals;

    typedef logic [1:0] imemRspState_t;

    localparam imemRspState_t IDLE = 2'd0;
    localparam imemRspState_t WAIT = 2'd1;
    localparam imemRspState_t RESP = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_storage.sv
// Instruction word storage: one synchronous write port, one asynchronous
// read port. A read in the same cycle as a write to the same word sees the
// old contents, since the write only lands on the clock edge.
module imem_storage #(
    parameter int unsigned DEPTH_POW = 10
) (
    input  logic                 clk_in,
    input  logic                 wr_en,
    input  logic [DEPTH_POW-1:0] wr_addr,
    input  logic [31:0]          wr_data,
    input  logic [DEPTH_POW-1:0] rd_addr,
    output logic [31:0]          rd_data
);

    logic [31:0] mem [0:(1 << DEPTH_POW) - 1];

    // Loader write port; contents are intentionally not reset.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder. A request is accepted in
// IDLE, its word and error flag are captured at accept, and the response is
// presented LATENCY cycles later (legal LATENCY range 1..15) until taken.
module imem_responder
    import ControlSignals::*;
#(
    parameter int unsigned ADDR_WIDTH_POW = 6,
    parameter int unsigned MEM_DEPTH_POW  = 10,
    parameter int unsigned LATENCY        = 1,
    localparam int unsigned ADDR_WIDTH    = 1 << ADDR_WIDTH_POW
) (
    input  logic                     clk_in,
    input  logic                     rst,
    input  logic                     req_valid_in,
    output logic                     req_ready_out,
    input  logic [ADDR_WIDTH-1:0]    req_addr_in,
    output logic                     rsp_valid_out,
    input  logic                     rsp_ready_in,
    output logic [31:0]              rsp_instr_out,
    output logic                     rsp_err_out,
    input  logic                     load_en_in,
    input  logic [MEM_DEPTH_POW-1:0] load_addr_in,
    input  logic [31:0]              load_data_in,
    output logic [31:0]              served_count_out
);

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    imemRspState_t       state;
    logic [3:0]          cnt;
    logic [31:0]         rd_data;
    logic                misaligned;
    logic                out_of_range;
    logic                req_err;
    logic                accept;
    logic                rsp_done;

    imem_storage #(
        .DEPTH_POW (MEM_DEPTH_POW)
    ) u_storage (
        .clk_in  (clk_in),
        .wr_en   (load_en_in),
        .wr_addr (load_addr_in),
        .wr_data (load_data_in),
        .rd_addr (req_addr_in[MEM_DEPTH_POW+1:2]),
        .rd_data (rd_data)
    );

    assign misaligned    = |req_addr_in[1:0];
    assign out_of_range  = (req_addr_in >> (MEM_DEPTH_POW + 2)) != '0;
    assign req_err       = misaligned || out_of_range;

    assign req_ready_out = (state == IDLE);
    assign rsp_valid_out = (state == RESP);
    assign accept        = req_valid_in && req_ready_out;
    assign rsp_done      = rsp_valid_out && rsp_ready_in;

    // Request FSM and latency counter.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response capture at accept; back to NOP once the response is taken.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rsp_instr_out <= INSTR_NOP;
            rsp_err_out   <= 1'b0;
        end else if (accept) begin
            rsp_instr_out <= req_err ? INSTR_NOP : rd_data;
            rsp_err_out   <= req_err;
        end else if (rsp_done) begin
            rsp_instr_out <= INSTR_NOP;
            rsp_err_out   <= 1'b0;
        end
    end

    // Completed-response counter, free-running wrap.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            served_count_out <= '0;
        end else if (rsp_done) begin
            served_count_out <= served_count_out + 32'd1;
        end
    end

endmodule
